// File: rtl/mem_bus_arbiter.sv
// Arbitrates one external memory bus between instruction fetch and load/store.
// MEM has priority; a starvation counter forces one IF grant after STARVE_LIMIT MEM grants.
module mem_bus_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        IF_Req,
  input  logic [31:0] IF_Addr,
  input  logic        IF_Flush,
  input  logic        IF_Advance,
  input  logic        MEM_Req,
  input  logic        MEM_Write,
  input  logic        MEM_Byte,
  input  logic        MEM_Half,
  input  logic        MEM_SignExt,
  input  logic [31:0] MEM_Addr,
  input  logic [31:0] MEM_WData,
  input  logic        MEM_Flush,
  input  logic        MEM_Advance,
  input  logic        Bus_Ack,
  input  logic [31:0] Bus_RData,
  output logic        IF_Stall,
  output logic        MEM_Stall,
  output logic [31:0] IF_Instruction,
  output logic [31:0] MEM_ReadData,
  output logic        MEM_AddrErr,
  output logic        Bus_Req,
  output logic        Bus_Write,
  output logic [31:0] Bus_Addr,
  output logic [31:0] Bus_WData,
  output logic [3:0]  Bus_BE
);

  localparam int unsigned CW = 4;
  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_IF_WAIT  = 2'd1;
  localparam logic [1:0] S_MEM_WAIT = 2'd2;

  logic [1:0]    r_state, w_state_nxt;
  logic          r_if_done, r_mem_done, r_discard;
  logic [CW-1:0] r_starve;
  logic          r_bus_req, r_bus_write;
  logic [31:0]   r_bus_addr, r_bus_wdata;
  logic [3:0]    r_bus_be;
  logic [31:0]   r_if_instr, r_mem_rdata;
  logic [1:0]    r_lane;
  logic          r_byte, r_half, r_sext;

  logic          w_addr_err, w_if_elig, w_mem_elig;
  logic          w_grant_if, w_grant_mem;
  logic          w_if_ack, w_mem_ack, w_if_discard;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata, w_load_data;
  logic [7:0]    w_lb;
  logic [15:0]   w_lh;
  logic          w_unused;

  assign w_unused     = ^IF_Addr[1:0];
  assign w_addr_err   = MEM_Req & ~MEM_Byte & (MEM_Half ? MEM_Addr[0] : (|MEM_Addr[1:0]));
  assign w_if_elig    = IF_Req & ~r_if_done & ~IF_Flush;
  assign w_mem_elig   = MEM_Req & ~r_mem_done & ~MEM_Flush & ~w_addr_err;
  assign w_if_ack     = Bus_Ack & (r_state == S_IF_WAIT);
  assign w_mem_ack    = Bus_Ack & (r_state == S_MEM_WAIT);
  // A flush arriving on the ack edge itself still squashes the fetch.
  assign w_if_discard = r_discard | IF_Flush;

  assign IF_Stall       = IF_Req & ~r_if_done;
  assign MEM_Stall      = MEM_Req & ~r_mem_done & ~w_addr_err;
  assign MEM_AddrErr    = w_addr_err;
  assign IF_Instruction = r_if_instr;
  assign MEM_ReadData   = r_mem_rdata;
  assign Bus_Req        = r_bus_req;
  assign Bus_Write      = r_bus_write;
  assign Bus_Addr       = r_bus_addr;
  assign Bus_WData      = r_bus_wdata;
  assign Bus_BE         = r_bus_be;

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next state and grant selection
  always_comb begin
    w_state_nxt = r_state;
    w_grant_if  = 1'b0;
    w_grant_mem = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_mem_elig && !(w_if_elig && (r_starve == CW'(STARVE_LIMIT)))) begin
          w_grant_mem = 1'b1;
          w_state_nxt = S_MEM_WAIT;
        end else if (w_if_elig) begin
          w_grant_if  = 1'b1;
          w_state_nxt = S_IF_WAIT;
        end
      end
      S_IF_WAIT, S_MEM_WAIT: begin
        if (Bus_Ack) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Store lane steering
  always_comb begin
    if (MEM_Byte) begin
      w_be    = 4'(4'b0001 << MEM_Addr[1:0]);
      w_wdata = {4{MEM_WData[7:0]}};
    end else if (MEM_Half) begin
      w_be    = MEM_Addr[1] ? 4'b1100 : 4'b0011;
      w_wdata = {2{MEM_WData[15:0]}};
    end else begin
      w_be    = 4'b1111;
      w_wdata = MEM_WData;
    end
  end

  // Load lane extraction using the attributes latched at issue
  always_comb begin
    case (r_lane)
      2'd0:    w_lb = Bus_RData[7:0];
      2'd1:    w_lb = Bus_RData[15:8];
      2'd2:    w_lb = Bus_RData[23:16];
      default: w_lb = Bus_RData[31:24];
    endcase
    w_lh = r_lane[1] ? Bus_RData[31:16] : Bus_RData[15:0];
    if (r_byte)      w_load_data = r_sext ? {{24{w_lb[7]}}, w_lb} : {24'h0, w_lb};
    else if (r_half) w_load_data = r_sext ? {{16{w_lh[15]}}, w_lh} : {16'h0, w_lh};
    else             w_load_data = Bus_RData;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_bus_req   <= 1'b0;
      r_bus_write <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
      r_bus_be    <= 4'h0;
      r_if_instr  <= 32'h0;
      r_mem_rdata <= 32'h0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_discard   <= 1'b0;
      r_starve    <= CW'(0);
      r_lane      <= 2'b00;
      r_byte      <= 1'b0;
      r_half      <= 1'b0;
      r_sext      <= 1'b0;
    end else begin
      if (w_grant_mem) begin
        r_bus_req   <= 1'b1;
        r_bus_write <= MEM_Write;
        r_bus_addr  <= {MEM_Addr[31:2], 2'b00};
        r_bus_wdata <= w_wdata;
        r_bus_be    <= w_be;
        r_lane      <= MEM_Addr[1:0];
        r_byte      <= MEM_Byte;
        r_half      <= MEM_Half;
        r_sext      <= MEM_SignExt;
      end else if (w_grant_if) begin
        r_bus_req   <= 1'b1;
        r_bus_write <= 1'b0;
        r_bus_addr  <= {IF_Addr[31:2], 2'b00};
        r_bus_wdata <= 32'h0;
        r_bus_be    <= 4'b1111;
      end else if (w_if_ack || w_mem_ack) begin
        r_bus_req   <= 1'b0;
        r_bus_write <= 1'b0;
      end

      if (w_grant_if)                     r_starve <= CW'(0);
      else if (w_grant_mem && w_if_elig)  r_starve <= r_starve + CW'(1);

      if (w_if_ack)                            r_discard <= 1'b0;
      else if (r_state == S_IF_WAIT && IF_Flush) r_discard <= 1'b1;

      if (w_if_ack && !w_if_discard) begin
        r_if_done  <= 1'b1;
        r_if_instr <= Bus_RData;
      end else if (r_if_done && IF_Advance) begin
        r_if_done  <= 1'b0;
      end

      if (w_mem_ack) begin
        r_mem_done <= 1'b1;
        if (!r_bus_write) r_mem_rdata <= w_load_data;
      end else if (r_mem_done && MEM_Advance) begin
        r_mem_done <= 1'b0;
      end
    end
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (load/store, byte/half/word).
- Generates IF_Stall and MEM_Stall for the pipeline stage registers.
- Holds returned instruction and load data until the consuming stage advances.
- Sits between the pipeline datapath and the memory interface; MEM has priority, with a starvation guard for IF.

Parameters:
STARVE_LIMIT, 4, consecutive MEM grants while IF is waiting before IF is forced one grant (1..15)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low (0 = reset)
IF_Req  in  1  fetch requested
IF_Addr  in  32  fetch address (word aligned; bits[1:0] ignored)
IF_Flush  in  1  current fetch is squashed
IF_Advance  in  1  IF/ID register captures this cycle
MEM_Req  in  1  = MemRead | MemWrite
MEM_Write  in  1  store when 1
MEM_Byte  in  1  byte access
MEM_Half  in  1  halfword access
MEM_SignExt  in  1  sign-extend byte/half loads
MEM_Addr  in  32  data address
MEM_WData  in  32  store data (low-aligned)
MEM_Flush  in  1  cancel not-yet-issued data access
MEM_Advance  in  1  MEM/WB register captures this cycle
Bus_Ack  in  1  one-cycle completion from memory
Bus_RData  in  32  read data, valid with Bus_Ack
IF_Stall  out  1  IF_Req & ~IF_Done
MEM_Stall  out  1  MEM_Req & ~MEM_Done & ~MEM_AddrErr
IF_Instruction  out  32  registered fetch data
MEM_ReadData  out  32  registered, lane-extracted load data
MEM_AddrErr  out  1  combinational misalignment flag
Bus_Req  out  1  registered bus request
Bus_Write  out  1  registered
Bus_Addr  out  32  registered, bits[1:0] forced 0
Bus_WData  out  32  registered, lane-replicated
Bus_BE  out  4  registered byte enables

Behaviour:
- Reset (rst=0 at edge): state IDLE; all registered outputs 0; IF_Done, MEM_Done, discard flag and starve counter cleared.
  - Reset mid-transaction drops Bus_Req next edge; memory tolerates the abort.
- States:
  - IDLE: select a requester using the priority and eligibility rules below and move to its WAIT state.
  - IF_WAIT, MEM_WAIT: Bus_* registered outputs are set on the edge leaving IDLE and held stable until Bus_Ack.
  - On Bus_Ack: capture data, set the requester's Done flag, return to IDLE. Minimum access is 2 cycles (issue edge, ack).
- Priority:
  - MEM wins if eligible, unless the starve counter equals STARVE_LIMIT, in which case IF wins.
  - Starve counter increments on each MEM grant while IF is eligible; it clears on any IF grant.
- Eligibility:
  - IF: IF_Req & ~IF_Done & ~IF_Flush.
  - MEM: MEM_Req & ~MEM_Done & ~MEM_Flush & ~MEM_AddrErr.
- Done flags:
  - Set on ack; cleared at an edge where the Done flag is 1 and Advance is 1.
  - While Done=1 the stall is low and output data is held. A port never re-issues while its Done flag is set.
- IF_Flush in IF_WAIT sets the discard flag. On ack, IF_Done is not set and IF_Instruction is unchanged; the discard flag clears. IF_Stall stays high throughout.
- MEM_Flush never aborts an issued MEM access.
- Alignment:
  - Half access with addr[0]=1, or word access with addr[1:0]≠0, gives MEM_AddrErr=1.
  - In that case no bus cycle is issued and MEM_Stall=0.
- Byte enables (little-endian):
  - byte: BE = 1 << addr[1:0].
  - half: BE = addr[1] ? 1100 : 0011.
  - word: BE = 1111.
- Write data: byte → {4{WData[7:0]}}; half → {2{WData[15:0]}}; word unchanged.
- Load extraction selects the lane by addr[1:0] and zero- or sign-extends it per MEM_SignExt. Store ack leaves MEM_ReadData unchanged.
- Bus_Ack outside a WAIT state is ignored.

Test Plan:
1. Reset: hold rst=0 with random inputs → all outputs 0, Bus_Req=0; first IF_Req after release gives Bus_Req=1 at the next edge.
2. Simultaneous IF_Req and MEM load (addr 0x1002, half, signext), Bus_RData=0x80FF0000 → MEM granted first, MEM_ReadData=0xFFFF80FF, MEM_Stall drops the cycle after ack; then IF is issued.
3. Store byte, addr 0x23, WData=0x5A → Bus_BE=1000, Bus_WData=0x5A5A5A5A, Bus_Addr=0x20, Bus_Write=1.
4. IF_Flush during IF_WAIT, ack with 0xDEADBEEF → IF_Instruction keeps its old value, IF_Stall stays 1, and a re-fetch issues from IDLE.
5. STARVE_LIMIT=2 with continuous MEM requests and IF pending → grant order MEM, MEM, IF.
6. Word load at addr 0x6 → MEM_AddrErr=1, Bus_Req stays 0, MEM_Stall=0; and with IF_Advance=0 after ack → IF_Stall stays 0 and data is held, no re-issue until IF_Advance=1.
